// File: rtl/reg_sel_pkg.sv
// reg_sel_pkg: shared state, phase and operand-count encodings for the register select sequencer
package reg_sel_pkg;
  typedef enum logic [2:0] {IDLE, SEL_B, SEL_C, SEL_A, DONE} state_t;
  localparam logic [1:0] PH_NONE = 2'd0;
  localparam logic [1:0] PH_B = 2'd1;
  localparam logic [1:0] PH_C = 2'd2;
  localparam logic [1:0] PH_A = 2'd3;
  localparam logic [1:0] OPS_A = 2'd0;
  localparam logic [1:0] OPS_BA = 2'd1;
  localparam logic [1:0] OPS_BCA = 2'd2;
endpackage

// File: rtl/reg_select_sequencer_onehot_dec.sv
// onehot_dec: binary register index to one-hot enable, one compare per output bit
module onehot_dec #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [W-1:0] idx,
  output logic [N-1:0] oh
);
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign oh[i] = idx == W'(i);
  end
endmodule

// File: rtl/reg_select_sequencer.sv
// reg_select_sequencer: IR latch, Ra/Rb/Rc one-hot select sequencing, manual select path and immediate sign extension
module reg_select_sequencer
  import reg_sel_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG = 16,
  parameter int RSEL_W = $clog2(NREG),
  parameter int RA_LSB = 23,
  parameter int RB_LSB = 19,
  parameter int RC_LSB = 15,
  parameter int IMM_W = 18
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ir_load,
  input  logic [DATA_W-1:0] ir_in,
  input  logic              start,
  input  logic [1:0]        ops,
  input  logic              adv,
  input  logic              ba_mode,
  input  logic              gra,
  input  logic              grb,
  input  logic              grc,
  input  logic              rin,
  input  logic              rout,
  input  logic              ba_out,
  output logic [NREG-1:0]   reg_in,
  output logic [NREG-1:0]   reg_out,
  output logic              zero_out,
  output logic [DATA_W-1:0] c_sext,
  output logic [1:0]        phase,
  output logic              busy,
  output logic              done
);
  state_t state, nxt;
  logic [DATA_W-1:0] ir_q;
  logic [1:0] ops_q;
  logic [RSEL_W-1:0] ra, rb, rc, sel, rd_idx, wr_idx;
  logic [NREG-1:0] rd_oh, wr_oh;
  logic idle, unused_hi;
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      ir_q <= '0;
      ops_q <= OPS_A;
    end else begin
      state <= nxt;
      if (state == IDLE && ir_load) ir_q <= ir_in;
      if (state == IDLE && start) ops_q <= ops;
    end
  end
  // reserved ops=3 falls through to the three-operand path
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  nxt = start ? (ops == OPS_A ? SEL_A : SEL_B) : IDLE;
      SEL_B: nxt = adv ? (ops_q == OPS_BA ? SEL_A : SEL_C) : SEL_B;
      SEL_C: nxt = adv ? SEL_A : SEL_C;
      SEL_A: nxt = adv ? DONE : SEL_A;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign ra = ir_q[RA_LSB +: RSEL_W];
  assign rb = ir_q[RB_LSB +: RSEL_W];
  assign rc = ir_q[RC_LSB +: RSEL_W];
  assign unused_hi = &{1'b0, ir_q[DATA_W-1:RA_LSB+RSEL_W]};
  assign idle = state == IDLE;
  assign sel = ({RSEL_W{gra}} & ra) | ({RSEL_W{grb}} & rb) | ({RSEL_W{grc}} & rc);
  assign rd_idx = state == SEL_C ? rc : state == SEL_B ? rb : sel;
  assign wr_idx = state == SEL_A ? ra : sel;
  onehot_dec #(.N(NREG), .W(RSEL_W)) u_rd_dec (.idx(rd_idx), .oh(rd_oh));
  onehot_dec #(.N(NREG), .W(RSEL_W)) u_wr_dec (.idx(wr_idx), .oh(wr_oh));
  // R0 as a base address reads as constant zero instead of the register
  assign zero_out = (state == SEL_B && ba_mode && rb == '0) || (idle && ba_out && sel == '0);
  assign reg_out = zero_out ? '0 :
                   (state == SEL_B || state == SEL_C || (idle && (rout || ba_out))) ? rd_oh : '0;
  assign reg_in = (state == SEL_A || (idle && rin)) ? wr_oh : '0;
  assign phase = state == SEL_B ? PH_B : state == SEL_C ? PH_C : state == SEL_A ? PH_A : PH_NONE;
  assign busy = !idle;
  assign done = state == DONE;
  assign c_sext = {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
endmodule

// File: tb/tb_reg_select_sequencer.sv
// tb_reg_select_sequencer: randomized and directed checks against a phase-list reference model
module tb_reg_select_sequencer;
  logic clk = 0, clr = 0, ir_load = 0, start = 0, adv = 0, ba_mode = 0;
  logic gra = 0, grb = 0, grc = 0, rin = 0, rout = 0, ba_out = 0;
  logic [31:0] ir_in = 0;
  logic [1:0] ops = 0;
  logic [15:0] reg_in, reg_out;
  logic zero_out, busy, done;
  logic [31:0] c_sext;
  logic [1:0] phase;
  int tests = 0, fails = 0;

  reg_select_sequencer dut (
    .clk(clk), .clr(clr), .ir_load(ir_load), .ir_in(ir_in), .start(start), .ops(ops),
    .adv(adv), .ba_mode(ba_mode), .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout),
    .ba_out(ba_out), .reg_in(reg_in), .reg_out(reg_out), .zero_out(zero_out),
    .c_sext(c_sext), .phase(phase), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sext_of(input logic [31:0] ir);
    logic [31:0] imm;
    imm = ir & 32'h0003FFFF;
    return ir[17] ? (imm | 32'hFFFC0000) : imm;
  endfunction

  task automatic clear_manual();
    gra = 0; grb = 0; grc = 0; rin = 0; rout = 0; ba_out = 0;
  endtask

  task automatic test_reset();
    clear_manual();
    clr = 1;
    tick();
    tick();
    clr = 0;
    #1;
    tests++; if (reg_in !== 16'h0) begin fails++; $display("FAIL reset_reg_in got %h exp 0", reg_in); end
    tests++; if (reg_out !== 16'h0) begin fails++; $display("FAIL reset_reg_out got %h exp 0", reg_out); end
    tests++; if (zero_out !== 1'b0) begin fails++; $display("FAIL reset_zero_out got %b exp 0", zero_out); end
    tests++; if (c_sext !== 32'h0) begin fails++; $display("FAIL reset_c_sext got %h exp 0", c_sext); end
    tests++; if (phase !== 2'd0) begin fails++; $display("FAIL reset_phase got %0d exp 0", phase); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
  endtask

  // One full sequence: phases follow from ops alone (B,C,A / B,A / A), each field one-hot via a shift.
  task automatic run_seq(input logic [31:0] ir, input logic [1:0] ops_v, input logic ba,
                         input int stall, input bit noise);
    int plist[$];
    int n;
    logic [3:0] ra, rb, rc;
    logic [15:0] e_ri, e_ro;
    logic e_zo;
    ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    if (ops_v == 0) plist = '{3};
    else if (ops_v == 1) plist = '{1, 3};
    else plist = '{1, 2, 3};
    clear_manual();
    ir_in = ir; ir_load = 1; start = 1; ops = ops_v; ba_mode = ba; adv = 0;
    tick();
    ir_load = 0; start = 0;
    foreach (plist[j]) begin
      n = stall < 0 ? int'($urandom_range(0, 2)) : stall;
      for (int k = 0; k <= n; k++) begin
        adv = k == n;
        if (noise && k < n) begin
          ir_in = $urandom; ir_load = 1'($urandom); start = 1'($urandom); ops = 2'($urandom);
          {gra, grb, grc, rin, rout, ba_out} = 6'($urandom);
        end else begin
          ir_load = 0; start = 0;
          clear_manual();
        end
        #1;
        e_zo = plist[j] == 1 && ba && rb == 0;
        e_ri = plist[j] == 3 ? 16'(1) << ra : 16'h0;
        e_ro = plist[j] == 1 ? (e_zo ? 16'h0 : 16'(1) << rb) : plist[j] == 2 ? 16'(1) << rc : 16'h0;
        tests++; if (reg_in !== e_ri) begin fails++; $display("FAIL seq_reg_in ph=%0d got %h exp %h", plist[j], reg_in, e_ri); end
        tests++; if (reg_out !== e_ro) begin fails++; $display("FAIL seq_reg_out ph=%0d got %h exp %h", plist[j], reg_out, e_ro); end
        tests++; if (zero_out !== e_zo) begin fails++; $display("FAIL seq_zero_out ph=%0d got %b exp %b", plist[j], zero_out, e_zo); end
        tests++; if (phase !== 2'(plist[j])) begin fails++; $display("FAIL seq_phase got %0d exp %0d", phase, plist[j]); end
        tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL seq_busy_done got %b%b exp 10", busy, done); end
        tests++; if (c_sext !== sext_of(ir)) begin fails++; $display("FAIL seq_c_sext got %h exp %h", c_sext, sext_of(ir)); end
        @(posedge clk);
        #1;
      end
    end
    adv = 0;
    #1;
    tests++; if (done !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL done_pulse got done=%b busy=%b exp 1 1", done, busy); end
    tests++; if (reg_in !== 0 || reg_out !== 0 || phase !== 0) begin fails++; $display("FAIL done_outputs got %h %h %0d exp 0 0 0", reg_in, reg_out, phase); end
    tick();
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL after_done got done=%b busy=%b exp 0 0", done, busy); end
  endtask

  task automatic test_three_op();
    run_seq(32'h029B8000, 2'd2, 1'b0, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_seq(32'h029B8000, 2'd1, 1'b0, 5, 1'b1);
  endtask

  task automatic test_ba_manual();
    logic [31:0] ir;
    logic [3:0] sel;
    logic [15:0] e_ri, e_ro;
    logic e_zo;
    run_seq(32'h02818000, 2'd2, 1'b1, 1, 1'b0);
    ir_in = 32'h0; ir_load = 1; tick(); ir_load = 0;
    grb = 1; ba_out = 1; #1;
    tests++; if (zero_out !== 1'b1 || reg_out !== 16'h0) begin fails++; $display("FAIL manual_ba_r0 got zo=%b ro=%h exp 1 0000", zero_out, reg_out); end
    clear_manual();
    ir_in = 32'h029B8000; ir_load = 1; tick(); ir_load = 0;
    grb = 1; rout = 1; #1;
    tests++; if (reg_out !== 16'h0008 || zero_out !== 1'b0) begin fails++; $display("FAIL manual_rout_rb got ro=%h zo=%b exp 0008 0", reg_out, zero_out); end
    clear_manual();
    for (int i = 0; i < 24; i++) begin
      ir = $urandom;
      if (i % 3 == 0) ir[26:15] = 12'h0;
      ir_in = ir; ir_load = 1; tick(); ir_load = 0;
      {gra, grb, grc, rin, rout, ba_out} = 6'($urandom);
      #1;
      sel = (gra ? ir[26:23] : 4'h0) | (grb ? ir[22:19] : 4'h0) | (grc ? ir[18:15] : 4'h0);
      e_zo = ba_out && sel == 0;
      e_ri = rin ? 16'(1) << sel : 16'h0;
      e_ro = (rout || ba_out) && !e_zo ? 16'(1) << sel : 16'h0;
      tests++; if (reg_in !== e_ri) begin fails++; $display("FAIL manual_reg_in got %h exp %h", reg_in, e_ri); end
      tests++; if (reg_out !== e_ro) begin fails++; $display("FAIL manual_reg_out got %h exp %h", reg_out, e_ro); end
      tests++; if (zero_out !== e_zo) begin fails++; $display("FAIL manual_zero_out got %b exp %b", zero_out, e_zo); end
      clear_manual();
    end
  endtask

  task automatic test_sext();
    ir_in = 32'h0003FFFF; ir_load = 1; tick(); ir_load = 0;
    tests++; if (c_sext !== 32'hFFFFFFFF) begin fails++; $display("FAIL sext_neg got %h exp ffffffff", c_sext); end
    ir_in = 32'h0001FFFF; ir_load = 1; tick(); ir_load = 0;
    tests++; if (c_sext !== 32'h0001FFFF) begin fails++; $display("FAIL sext_pos got %h exp 0001ffff", c_sext); end
  endtask

  task automatic test_clr_mid();
    ir_in = 32'h029B8000; ir_load = 1; start = 1; ops = 2; adv = 0; tick();
    ir_load = 0; start = 0; adv = 1; tick();
    tests++; if (phase !== 2'd2) begin fails++; $display("FAIL clr_pre_phase got %0d exp 2", phase); end
    clr = 1; tick(); clr = 0; adv = 0; #1;
    tests++; if (phase !== 0 || busy !== 0 || done !== 0) begin fails++; $display("FAIL clr_mid_state got ph=%0d busy=%b done=%b exp 0 0 0", phase, busy, done); end
    tests++; if (reg_in !== 0 || reg_out !== 0 || c_sext !== 0) begin fails++; $display("FAIL clr_mid_outputs got %h %h %h exp 0 0 0", reg_in, reg_out, c_sext); end
    tick();
    tests++; if (done !== 0 || busy !== 0) begin fails++; $display("FAIL clr_no_done got done=%b busy=%b exp 0 0", done, busy); end
  endtask

  task automatic test_random();
    logic [31:0] ir;
    for (int i = 0; i < 20; i++) begin
      ir = $urandom;
      if ($urandom_range(0, 1) == 1) ir[22:19] = 4'h0;
      run_seq(ir, 2'($urandom_range(0, 3)), 1'($urandom), -1, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_three_op();
    test_stall();
    test_ba_manual();
    test_sext();
    test_clr_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
